// File: rtl/dma_frame_scheduler_if.sv
// dma_frame_scheduler_if: command/completion channel between the frame scheduler and the DMA reader
interface dma_frame_scheduler_if #(
  parameter int AddrBits = 32,
  parameter int LengthBits = 16
) ();
  logic cfg_valid;
  logic cfg_ready;
  logic [AddrBits-1:0] cfg_addr;
  logic [LengthBits-1:0] cfg_len;
  logic dma_done;
  modport master (output cfg_valid, cfg_addr, cfg_len, input cfg_ready, dma_done);
  modport slave (input cfg_valid, cfg_addr, cfg_len, output cfg_ready, dma_done);
endinterface

// File: rtl/dma_frame_scheduler.sv
// dma_frame_scheduler: issues one DMA command per frame line and tracks completions
// Optional continuous re-issue of the latched frame under DMA_SCHED_CONTINUOUS_EN.
module dma_frame_scheduler #(
  parameter int AddrBits = 32,
  parameter int LengthBits = 16,
  parameter int LineBits = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [AddrBits-1:0] frame_base,
  input  logic [LengthBits-1:0] line_words,
  input  logic [AddrBits-1:0] line_stride,
  input  logic [LineBits-1:0] num_lines,
`ifdef DMA_SCHED_CONTINUOUS_EN
  input  logic cont,
`endif
  dma_frame_scheduler_if.master cfg,
  output logic busy,
  output logic frame_done,
  output logic aborted
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  state_t state, state_nx;
  logic [AddrBits-1:0] base_q, stride_q, addr_q;
  logic [LengthBits-1:0] len_q;
  logic [LineBits-1:0] lines_q, issued, completed, issued_nx, completed_nx;
  logic abort_seen, hs, done_inc, go, restart;
  assign hs = state == ISSUE && cfg.cfg_ready;
  assign done_inc = state != IDLE && cfg.dma_done && completed != issued;
  assign issued_nx = issued + LineBits'(hs);
  assign completed_nx = completed + LineBits'(done_inc);
  assign go = start && num_lines != '0 && line_words != '0;
`ifdef DMA_SCHED_CONTINUOUS_EN
  // a zero-size frame has nothing to repeat, so it never restarts
  assign restart = cont && !abort_seen && lines_q != '0 && len_q != '0;
`else
  assign restart = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    cfg.cfg_valid = state == ISSUE;
    cfg.cfg_addr = addr_q;
    cfg.cfg_len = len_q;
    busy = state != IDLE;
    frame_done = state == FINISH && !abort_seen;
    aborted = state == FINISH && abort_seen;
    case (state)
      IDLE: state_nx = start ? (go ? ISSUE : FINISH) : IDLE;
      ISSUE: state_nx = hs && (issued_nx == lines_q || abort) ? DRAIN : ISSUE;
      DRAIN: state_nx = completed_nx == issued ? FINISH : DRAIN;
      default: state_nx = restart ? ISSUE : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      stride_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      lines_q <= '0;
      issued <= '0;
      completed <= '0;
      abort_seen <= 1'b0;
    end else if (state == IDLE && start) begin
      base_q <= frame_base;
      stride_q <= line_stride;
      addr_q <= frame_base;
      len_q <= line_words;
      lines_q <= num_lines;
      issued <= '0;
      completed <= '0;
      abort_seen <= 1'b0;
    end else if (state == FINISH && restart) begin
      addr_q <= base_q;
      issued <= '0;
      completed <= '0;
    end else begin
      issued <= issued_nx;
      completed <= completed_nx;
      addr_q <= hs ? addr_q + stride_q : addr_q;
      abort_seen <= abort_seen || (hs && abort);
    end
  end
endmodule

// File: tb/tb_dma_frame_scheduler.sv
// tb_dma_frame_scheduler: randomized and directed frames checked against a line-list model
module tb_dma_frame_scheduler;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [31:0] frame_base = 0, line_stride = 0;
  logic [15:0] line_words = 0;
  logic [11:0] num_lines = 0;
  logic busy, frame_done, aborted;
`ifdef DMA_SCHED_CONTINUOUS_EN
  logic cont = 0;
`endif
  dma_frame_scheduler_if #(.AddrBits(32), .LengthBits(16)) bus ();
  dma_frame_scheduler #(.AddrBits(32), .LengthBits(16), .LineBits(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_base(frame_base), .line_words(line_words), .line_stride(line_stride), .num_lines(num_lines),
`ifdef DMA_SCHED_CONTINUOUS_EN
    .cont(cont),
`endif
    .cfg(bus.master), .busy(busy), .frame_done(frame_done), .aborted(aborted)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] got_addr[$];
  logic [15:0] got_len[$];
  int hs_cyc[$], due[$];
  int n_fd, n_ab, n_dd, last_dd, fd_cyc, hold, hold_line = -1, abort_line = -1, rdy_pct = 100;
  int lat_lo = 1, lat_hi = 8;
  logic held = 0, force_done = 0;
  logic [31:0] cur_base = 0, cur_stride = 0;
  logic [15:0] cur_w = 0;
  int cur_n = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic pv, pr;
    logic [31:0] ea;
    pv = bus.cfg_valid;
    pr = bus.cfg_ready;
    if (pv && pr) begin
      got_addr.push_back(bus.cfg_addr);
      got_len.push_back(bus.cfg_len);
      hs_cyc.push_back(cyc);
      due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
    end
    if (bus.dma_done) begin n_dd++; last_dd = cyc; end
    if (frame_done) begin n_fd++; fd_cyc = cyc; end
    if (aborted) begin n_ab++; fd_cyc = cyc; end
    @(posedge clk);
    #1;
    cyc++;
    if (pv && !pr && rst_n) check("hold_valid", bus.cfg_valid, 1);
    if (bus.cfg_valid && cur_n != 0) begin
      ea = cur_base + (got_addr.size() % cur_n) * cur_stride;
      check("present_addr", bus.cfg_addr, ea);
      check("present_len", bus.cfg_len, cur_w);
    end
    if (force_done) bus.dma_done = 1;
    else if (due.size() > 0 && due[0] <= cyc) begin bus.dma_done = 1; void'(due.pop_front()); end
    else bus.dma_done = 0;
    if (hold_line >= 0 && !held && got_addr.size() == hold_line && bus.cfg_valid) begin held = 1; hold = 4; end
    if (hold > 0) begin bus.cfg_ready = 0; hold--; end
    else bus.cfg_ready = $urandom_range(99) < rdy_pct;
    if (abort_line >= 0 && got_addr.size() >= abort_line && busy) abort = 1;
  endtask
  task automatic setup(input logic [31:0] b, input logic [15:0] w, input logic [31:0] s, input logic [11:0] n,
                       input int pct, input int hl, input int al);
    got_addr.delete(); got_len.delete(); hs_cyc.delete();
    n_fd = 0; n_ab = 0; n_dd = 0; last_dd = -1; fd_cyc = -1; held = 0; hold = 0;
    cur_base = b; cur_stride = s; cur_w = w; cur_n = int'(n);
    rdy_pct = pct; hold_line = hl; abort_line = al;
    frame_base = b; line_words = w; line_stride = s; num_lines = n;
  endtask
  task automatic frame(input logic [31:0] b, input logic [15:0] w, input logic [31:0] s, input logic [11:0] n,
                       input int pct, input int hl, input int al, input logic spur);
    int exp_n;
    logic ab;
    logic [31:0] ea;
    exp_n = (n == 0 || w == 0) ? 0 : (al >= 0 && al < int'(n)) ? al + 1 : int'(n);
    ab = exp_n != 0 && al >= 0 && al < int'(n);
    setup(b, w, s, n, pct, hl, al);
    start = 1;
    force_done = spur;
    tick();
    start = 0;
    force_done = 0;
    check("start_busy", busy, 1);
    check("start_valid", bus.cfg_valid, exp_n != 0);
    check("zero_done", frame_done, exp_n == 0);
    frame_base = $urandom; line_words = 16'($urandom); line_stride = $urandom; num_lines = 12'($urandom);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3000 && busy; i++) tick();
    check("frame_end_idle", busy, 0);
    abort = 0;
    check("lines", got_addr.size(), exp_n);
    for (int i = 0; i < got_addr.size(); i++) begin
      ea = b + i * s;
      check("addr", got_addr[i], ea);
      check("len", got_len[i], w);
    end
    check("frame_done_cnt", n_fd, !ab);
    check("aborted_cnt", n_ab, ab);
    if (exp_n != 0) begin
      check("done_cnt", n_dd, exp_n + int'(spur));
      check("finish_timing", fd_cyc, last_dd + 1);
    end
    if (pct == 100 && hl < 0 && exp_n > 1) check("no_bubble", hs_cyc[exp_n-1] - hs_cyc[0], exp_n - 1);
    repeat (3) tick();
  endtask
  initial begin
    bus.cfg_ready = 0;
    bus.dma_done = 0;
    repeat (3) tick();
    check("rst_valid", bus.cfg_valid, 0);
    check("rst_addr", bus.cfg_addr, 0);
    check("rst_len", bus.cfg_len, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_aborted", aborted, 0);
    rst_n = 1;
    tick();
    lat_lo = 5; lat_hi = 5;
    frame(32'h1000, 16, 32'h200, 3, 100, -1, -1, 0);
    lat_lo = 1; lat_hi = 8;
    frame(32'h1000, 16, 32'h200, 3, 100, 1, -1, 0);
    frame(32'hFFFF_FF00, 8, 32'h100, 2, 100, -1, -1, 0);
    frame(32'h2000, 4, 32'h40, 4, 100, 1, 1, 0);
    frame(32'h3000, 4, 32'h40, 0, 100, -1, -1, 0);
    frame(32'h3000, 0, 32'h40, 3, 100, -1, -1, 0);
    frame(32'h4000, 12, 32'h80, 3, 70, -1, -1, 1);
    for (int k = 0; k < 8; k++) begin
      int n, al;
      n = int'($urandom_range(6, 1));
      al = ($urandom_range(2) == 0) ? int'($urandom_range(n - 1)) : -1;
      frame($urandom & 32'hFFFF_FFFC, 16'($urandom_range(65535, 1)), $urandom & 32'hFFFF_FFFC,
            12'(n), int'($urandom_range(100, 30)), -1, al, 0);
    end
    setup(32'h5000, 8, 32'h20, 6, 100, -1, -1);
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    rst_n = 0;
    tick();
    check("midrst_valid", bus.cfg_valid, 0);
    check("midrst_busy", busy, 0);
    due.delete();
    force_done = 0;
    bus.dma_done = 0;
    rst_n = 1;
    repeat (10) tick();
    check("postrst_valid", bus.cfg_valid, 0);
    check("postrst_busy", busy, 0);
    frame(32'h6000, 32, 32'h400, 2, 100, -1, -1, 0);
`ifdef DMA_SCHED_CONTINUOUS_EN
    cont = 1;
    setup(32'h8000, 8, 32'h40, 2, 100, -1, -1);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 500 && n_fd == 0; i++) tick();
    check("cont_first_done", n_fd, 1);
    check("cont_restart_valid", bus.cfg_valid, 1);
    check("cont_restart_addr", bus.cfg_addr, 32'h8000);
    check("cont_restart_busy", busy, 1);
    cont = 0;
    n_fd = 0;
    for (int i = 0; i < 500 && busy; i++) tick();
    check("cont_end_idle", busy, 0);
    check("cont_extra_frames", n_fd, 1);
    check("cont_total_lines", got_addr.size(), 4);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
